l1_request_arbiter: RTL and testbench

- Parametrised N-port request arbiter between NUM_PORTS L1 caches and one shared downstream cache port (coherence controller / Lx request side).
- Generalises the fixed two-L1 point-to-point hookup to any port count.
- Round-robin fair grant with one outstanding transaction at a time.
- Routes the response to the granting port and adds a watchdog timeout flag.

---
 rtl/l1_request_arbiter_if.sv | 46 ++++
 rtl/l1_request_arbiter.sv | 154 +++++++++++++++
 tb/tb_l1_request_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/l1_request_arbiter_if.sv
// l1_request_arbiter_if: request/response bundle between the L1 caches, the arbiter and the downstream port.
// slave is the arbiter side, master is the side that drives requests and downstream responses.
interface l1_request_arbiter_if #(
    parameter int STATUS_BITS    = 2,
    parameter int COHERENCE_BITS = 2,
    parameter int OFFSET_BITS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 3,
    parameter int NUM_PORTS      = 4
);
    localparam int BUS_WIDTH = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * (1 << OFFSET_BITS);
    localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS*MSG_BITS-1:0]      cache2arb_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] cache2arb_address;
    logic [NUM_PORTS*BUS_WIDTH-1:0]     cache2arb_data;
    logic [NUM_PORTS*MSG_BITS-1:0]      arb2cache_msg;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] arb2cache_address;
    logic [NUM_PORTS*BUS_WIDTH-1:0]     arb2cache_data;
    logic [MSG_BITS-1:0]                arb2lx_msg;
    logic [ADDRESS_WIDTH-1:0]           arb2lx_address;
    logic [BUS_WIDTH-1:0]               arb2lx_data;
    logic [MSG_BITS-1:0]                lx2arb_msg;
    logic [ADDRESS_WIDTH-1:0]           lx2arb_address;
    logic [BUS_WIDTH-1:0]               lx2arb_data;
    logic                               grant_valid;
    logic [PORT_BITS-1:0]               grant_id;
    logic                               timeout_error;

    modport slave (
        input  cache2arb_msg, cache2arb_address, cache2arb_data,
        input  lx2arb_msg, lx2arb_address, lx2arb_data,
        output arb2cache_msg, arb2cache_address, arb2cache_data,
        output arb2lx_msg, arb2lx_address, arb2lx_data,
        output grant_valid, grant_id, timeout_error
    );

    modport master (
        output cache2arb_msg, cache2arb_address, cache2arb_data,
        output lx2arb_msg, lx2arb_address, lx2arb_data,
        input  arb2cache_msg, arb2cache_address, arb2cache_data,
        input  arb2lx_msg, arb2lx_address, arb2lx_data,
        input  grant_valid, grant_id, timeout_error
    );
endinterface

// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter: round-robin arbiter from NUM_PORTS L1 caches onto one downstream cache port.
// One transaction in flight; the response is routed back to the granted port, with a sticky watchdog flag.
module l1_request_arbiter #(
    parameter int STATUS_BITS    = 2,
    parameter int COHERENCE_BITS = 2,
    parameter int OFFSET_BITS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 3,
    parameter int NUM_PORTS      = 4,
    parameter int NO_REQ         = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic                 clock,
    input logic                 reset,
    l1_request_arbiter_if.slave bus
);
    localparam int BUS_WIDTH = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * (1 << OFFSET_BITS);
    localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WD_BITS   = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [MSG_BITS-1:0]  IDLE_MSG  = MSG_BITS'(NO_REQ);
    localparam logic [WD_BITS-1:0]   WD_LIMIT  = WD_BITS'(TIMEOUT_CYCLES);
    localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, RELEASE} state_t;

    state_t                             state_q, state_d;
    logic [PORT_BITS-1:0]               rr_ptr_q, rr_ptr_d;
    logic [PORT_BITS-1:0]               grant_id_q, grant_id_d;
    logic                               grant_valid_q, grant_valid_d;
    logic                               timeout_error_q, timeout_error_d;
    logic [WD_BITS-1:0]                 wd_q, wd_d;
    logic [MSG_BITS-1:0]                arb2lx_msg_q, arb2lx_msg_d;
    logic [ADDRESS_WIDTH-1:0]           arb2lx_address_q, arb2lx_address_d;
    logic [BUS_WIDTH-1:0]               arb2lx_data_q, arb2lx_data_d;
    logic [NUM_PORTS*MSG_BITS-1:0]      arb2cache_msg_q, arb2cache_msg_d;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] arb2cache_address_q, arb2cache_address_d;
    logic [NUM_PORTS*BUS_WIDTH-1:0]     arb2cache_data_q, arb2cache_data_d;
    logic                               req_found;
    logic [PORT_BITS-1:0]               req_port;
    logic                               resp_match;
    logic                               release_ok;

    // Scan from the far end back towards rr_ptr so the closest requester wins.
    always_comb begin
        req_found = 1'b0;
        req_port  = rr_ptr_q;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.cache2arb_msg[((int'(rr_ptr_q) + i) % NUM_PORTS) * MSG_BITS +: MSG_BITS] != IDLE_MSG) begin
                req_found = 1'b1;
                req_port  = PORT_BITS'((int'(rr_ptr_q) + i) % NUM_PORTS);
            end
        end
    end

    // arb2lx_address_q doubles as the latched request address used for response matching.
    assign resp_match = (bus.lx2arb_msg != IDLE_MSG) && (bus.lx2arb_address == arb2lx_address_q);
    assign release_ok = (bus.cache2arb_msg[int'(grant_id_q) * MSG_BITS +: MSG_BITS] == IDLE_MSG) &&
                        (bus.lx2arb_msg == IDLE_MSG);

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_id_d          = grant_id_q;
        grant_valid_d       = grant_valid_q;
        timeout_error_d     = timeout_error_q;
        wd_d                = wd_q;
        arb2lx_msg_d        = arb2lx_msg_q;
        arb2lx_address_d    = arb2lx_address_q;
        arb2lx_data_d       = arb2lx_data_q;
        arb2cache_msg_d     = arb2cache_msg_q;
        arb2cache_address_d = arb2cache_address_q;
        arb2cache_data_d    = arb2cache_data_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    arb2lx_msg_d     = bus.cache2arb_msg[int'(req_port) * MSG_BITS +: MSG_BITS];
                    arb2lx_address_d = bus.cache2arb_address[int'(req_port) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    arb2lx_data_d    = bus.cache2arb_data[int'(req_port) * BUS_WIDTH +: BUS_WIDTH];
                    grant_valid_d    = 1'b1;
                    grant_id_d       = req_port;
                    wd_d             = '0;
                    state_d          = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;
                if (TIMEOUT_CYCLES != 0 && wd_d == WD_LIMIT)
                    timeout_error_d = 1'b1;
                if (resp_match) begin
                    arb2lx_msg_d        = IDLE_MSG;
                    arb2cache_msg_d     = '0;
                    arb2cache_address_d = '0;
                    arb2cache_data_d    = '0;
                    arb2cache_msg_d[int'(grant_id_q) * MSG_BITS +: MSG_BITS]               = bus.lx2arb_msg;
                    arb2cache_address_d[int'(grant_id_q) * ADDRESS_WIDTH +: ADDRESS_WIDTH] = bus.lx2arb_address;
                    arb2cache_data_d[int'(grant_id_q) * BUS_WIDTH +: BUS_WIDTH]            = bus.lx2arb_data;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (release_ok) begin
                    arb2cache_msg_d     = '0;
                    arb2cache_address_d = '0;
                    arb2cache_data_d    = '0;
                    grant_valid_d       = 1'b0;
                    rr_ptr_d            = (grant_id_q == LAST_PORT) ? '0 : grant_id_q + 1'b1;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_id_q          <= '0;
            grant_valid_q       <= 1'b0;
            timeout_error_q     <= 1'b0;
            wd_q                <= '0;
            arb2lx_msg_q        <= IDLE_MSG;
            arb2lx_address_q    <= '0;
            arb2lx_data_q       <= '0;
            arb2cache_msg_q     <= '0;
            arb2cache_address_q <= '0;
            arb2cache_data_q    <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_id_q          <= grant_id_d;
            grant_valid_q       <= grant_valid_d;
            timeout_error_q     <= timeout_error_d;
            wd_q                <= wd_d;
            arb2lx_msg_q        <= arb2lx_msg_d;
            arb2lx_address_q    <= arb2lx_address_d;
            arb2lx_data_q       <= arb2lx_data_d;
            arb2cache_msg_q     <= arb2cache_msg_d;
            arb2cache_address_q <= arb2cache_address_d;
            arb2cache_data_q    <= arb2cache_data_d;
        end
    end

    assign bus.arb2lx_msg        = arb2lx_msg_q;
    assign bus.arb2lx_address    = arb2lx_address_q;
    assign bus.arb2lx_data       = arb2lx_data_q;
    assign bus.arb2cache_msg     = arb2cache_msg_q;
    assign bus.arb2cache_address = arb2cache_address_q;
    assign bus.arb2cache_data    = arb2cache_data_q;
    assign bus.grant_valid       = grant_valid_q;
    assign bus.grant_id          = grant_id_q;
    assign bus.timeout_error     = timeout_error_q;
endmodule

// File: tb/tb_l1_request_arbiter.sv
// tb_l1_request_arbiter: directed vectors plus hand-written sequences for the 4-port arbiter.
module tb_l1_request_arbiter;
    localparam int NP = 4;
    localparam int MB = 3;
    localparam int AW = 32;
    localparam int BW = 132;
    localparam int W  = NP * BW;
    localparam logic [BW-1:0] RESP_DATA = {4'h5, {4{32'hDEAD_BEEF}}};

    typedef struct {
        logic [NP*MB-1:0] cmsg;
        logic [MB-1:0]    lmsg;
        logic [AW-1:0]    laddr;
        logic [MB-1:0]    e_lmsg;
        logic [AW-1:0]    e_laddr;
        logic             e_gv;
        logic [1:0]       e_gid;
        int               e_slot;
        logic [MB-1:0]    e_rmsg;
        logic [AW-1:0]    e_raddr;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [AW-1:0] port_addr [NP];
    vec_t        vecs [9];

    l1_request_arbiter_if bus();
    l1_request_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic logic [BW-1:0] port_data(input int p);
        return {4'(p), {4{32'hC0DE_0000 + 32'(p)}}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_slots(input string tag, input int slot, input logic [MB-1:0] rmsg, input logic [AW-1:0] raddr);
        logic [NP*MB-1:0] em;
        logic [NP*AW-1:0] ea;
        logic [W-1:0]     ed;
        em = '0;
        ea = '0;
        ed = '0;
        if (slot >= 0) begin
            em[slot*MB +: MB] = rmsg;
            ea[slot*AW +: AW] = raddr;
            ed[slot*BW +: BW] = RESP_DATA;
        end
        check({tag, " cache_msg"}, W'(bus.arb2cache_msg), W'(em));
        check({tag, " cache_addr"}, W'(bus.arb2cache_address), W'(ea));
        check({tag, " cache_data"}, bus.arb2cache_data, ed);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " lx_msg"}, W'(bus.arb2lx_msg), W'(0));
        check({tag, " lx_addr"}, W'(bus.arb2lx_address), W'(0));
        check({tag, " lx_data"}, W'(bus.arb2lx_data), W'(0));
        check({tag, " grant_valid"}, W'(bus.grant_valid), W'(0));
        check({tag, " grant_id"}, W'(bus.grant_id), W'(0));
        check({tag, " timeout"}, W'(bus.timeout_error), W'(0));
        check_slots(tag, -1, '0, '0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.cache2arb_msg  = '0;
        bus.lx2arb_msg     = '0;
        bus.lx2arb_address = '0;
        reset = 1'b1;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;
    endtask

    initial begin
        port_addr = '{32'h100, 32'h200, 32'h40, 32'h300};
        bus.cache2arb_msg     = '0;
        bus.lx2arb_msg        = '0;
        bus.lx2arb_address    = '0;
        bus.lx2arb_data       = RESP_DATA;
        for (int p = 0; p < NP; p++) begin
            bus.cache2arb_address[p*AW +: AW] = port_addr[p];
            bus.cache2arb_data[p*BW +: BW]    = port_data(p);
        end
        vecs[0] = '{12'h040, 3'd0, 32'h00, 3'd1, 32'h40, 1'b1, 2'd2, -1, 3'd0, 32'h00};
        vecs[1] = '{12'h040, 3'd3, 32'h40, 3'd0, 32'h40, 1'b1, 2'd2,  2, 3'd3, 32'h40};
        vecs[2] = '{12'h000, 3'd0, 32'h00, 3'd0, 32'h40, 1'b0, 2'd2, -1, 3'd0, 32'h00};
        vecs[3] = '{12'h040, 3'd0, 32'h00, 3'd1, 32'h40, 1'b1, 2'd2, -1, 3'd0, 32'h00};
        vecs[4] = '{12'h040, 3'd3, 32'h80, 3'd1, 32'h40, 1'b1, 2'd2, -1, 3'd0, 32'h00};
        vecs[5] = '{12'h040, 3'd0, 32'h00, 3'd1, 32'h40, 1'b1, 2'd2, -1, 3'd0, 32'h00};
        vecs[6] = '{12'h040, 3'd3, 32'h40, 3'd0, 32'h40, 1'b1, 2'd2,  2, 3'd3, 32'h40};
        vecs[7] = '{12'h040, 3'd0, 32'h00, 3'd0, 32'h40, 1'b1, 2'd2,  2, 3'd3, 32'h40};
        vecs[8] = '{12'h000, 3'd0, 32'h00, 3'd0, 32'h40, 1'b0, 2'd2, -1, 3'd0, 32'h00};

        #2;
        do_reset();
        foreach (vecs[i]) begin
            bus.cache2arb_msg  = vecs[i].cmsg;
            bus.lx2arb_msg     = vecs[i].lmsg;
            bus.lx2arb_address = vecs[i].laddr;
            step();
            check($sformatf("v%0d lx_msg", i), W'(bus.arb2lx_msg), W'(vecs[i].e_lmsg));
            check($sformatf("v%0d lx_addr", i), W'(bus.arb2lx_address), W'(vecs[i].e_laddr));
            check($sformatf("v%0d lx_data", i), W'(bus.arb2lx_data), W'(port_data(int'(vecs[i].e_gid))));
            check($sformatf("v%0d grant_valid", i), W'(bus.grant_valid), W'(vecs[i].e_gv));
            check($sformatf("v%0d grant_id", i), W'(bus.grant_id), W'(vecs[i].e_gid));
            check_slots($sformatf("v%0d", i), vecs[i].e_slot, vecs[i].e_rmsg, vecs[i].e_raddr);
        end

        // All four ports keep requesting: grants must rotate 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.cache2arb_msg = 12'h249;
            bus.lx2arb_msg    = '0;
            step();
            check($sformatf("rr%0d grant_id", k), W'(bus.grant_id), W'(k % NP));
            check($sformatf("rr%0d lx_addr", k), W'(bus.arb2lx_address), W'(port_addr[k % NP]));
            check($sformatf("rr%0d lx_data", k), W'(bus.arb2lx_data), W'(port_data(k % NP)));
            bus.lx2arb_msg     = 3'd3;
            bus.lx2arb_address = port_addr[k % NP];
            step();
            check_slots($sformatf("rr%0d", k), k % NP, 3'd3, port_addr[k % NP]);
            bus.cache2arb_msg[(k % NP)*MB +: MB] = '0;
            bus.lx2arb_msg = '0;
            step();
            check($sformatf("rr%0d release", k), W'(bus.grant_valid), W'(0));
        end

        // Silent downstream: watchdog fires after 8 WAIT_RESP cycles and stays set.
        do_reset();
        bus.cache2arb_msg = 12'h008;
        step();
        check("to grant_id", W'(bus.grant_id), W'(1));
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("to cycle%0d", c), W'(bus.timeout_error), W'(c >= 8));
            check($sformatf("to wait%0d", c), W'(bus.grant_valid), W'(1));
        end
        bus.lx2arb_msg     = 3'd3;
        bus.lx2arb_address = 32'h200;
        step();
        check_slots("to late", 1, 3'd3, 32'h200);
        bus.cache2arb_msg = '0;
        bus.lx2arb_msg    = '0;
        step();
        check("to done gv", W'(bus.grant_valid), W'(0));
        check("to sticky", W'(bus.timeout_error), W'(1));

        // Reset in WAIT_RESP after rr_ptr has moved to 3.
        do_reset();
        bus.cache2arb_msg = 12'h040;
        step();
        bus.lx2arb_msg     = 3'd3;
        bus.lx2arb_address = 32'h40;
        step();
        bus.cache2arb_msg = '0;
        bus.lx2arb_msg    = '0;
        step();
        bus.cache2arb_msg = 12'h001;
        step();
        check("mid grant_id", W'(bus.grant_id), W'(0));
        step();
        check("mid waiting", W'(bus.grant_valid), W'(1));
        #3;
        reset = 1'b1;
        #1;
        check_zero("mid async");
        bus.cache2arb_msg  = '0;
        bus.lx2arb_msg     = 3'd3;
        bus.lx2arb_address = 32'h100;
        step();
        reset = 1'b0;
        step();
        check_slots("mid after", -1, '0, '0);
        check("mid after gv", W'(bus.grant_valid), W'(0));
        bus.lx2arb_msg    = '0;
        bus.cache2arb_msg = 12'h201;
        step();
        check("mid rr_ptr", W'(bus.grant_id), W'(0));

        // Requester withdraws while waiting: response is shown for exactly one cycle.
        do_reset();
        bus.cache2arb_msg = 12'h200;
        step();
        check("wd grant_id", W'(bus.grant_id), W'(3));
        bus.cache2arb_msg = '0;
        step();
        check("wd waiting", W'(bus.grant_valid), W'(1));
        check_slots("wd waiting", -1, '0, '0);
        bus.lx2arb_msg     = 3'd3;
        bus.lx2arb_address = 32'h300;
        step();
        check_slots("wd resp", 3, 3'd3, 32'h300);
        bus.lx2arb_msg = '0;
        step();
        check_slots("wd cleared", -1, '0, '0);
        check("wd idle", W'(bus.grant_valid), W'(0));
        step();
        check("wd stays idle", W'(bus.grant_valid), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
